// File: rtl/register_serial_reader.sv
// Captures a parallel word on start and streams it out one bit per ready
// handshake, MSB- or LSB-first, with a one-cycle done pulse at the end.
module register_serial_reader #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         D,
  input  logic                     ready,
  output logic                     sout,
  output logic                     sout_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic sout_d, sout_valid_d, busy_d, done_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = D;
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ready) begin
          shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          // Counter saturates on the last bit so it never wraps
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        shreg_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs track state_q
  always_comb begin
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    unique case (state_d)
      S_SHIFT: begin
        sout_valid_d = 1'b1;
        busy_d       = 1'b1;
        sout_d       = LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1];
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        sout_d = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      sout       <= sout_d;
      sout_valid <= sout_valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  assign bit_idx = idx_q;

endmodule
